// File: rtl/stopwatch_adj_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_adj_ctrl
//  Purpose  : Single-clock stopwatch minutes/seconds keeper with RUN/PAUSE
//             run-state and per-field adjust overlay driven by tick enables.
//             Optional display blink on the adjusted field: STOPWATCH_BLINK_EN
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_adj_ctrl #(
    parameter int MIN_W   = 6,
    parameter int SEC_W   = 6,
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_adj,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_p,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             paused,
    output logic             adjusting,
    output logic             wrap_p,
    output logic             min_blank,
    output logic             sec_blank
);

    localparam logic [0:0]       c_st_run   = 1'b0;
    localparam logic [0:0]       c_st_pause = 1'b1;
    localparam logic [MIN_W-1:0] c_min_max  = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] c_sec_max  = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] c_min_one  = MIN_W'(1);
    localparam logic [SEC_W-1:0] c_sec_one  = SEC_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [MIN_W-1:0] r_min;
    logic [MIN_W-1:0] w_min_next;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec_next;
    logic             r_adjusting;
    logic             r_wrap;
    logic             w_wrap_next;
    logic             w_paused;

    // Run-state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pause pulses arriving during adjust are dropped, not queued
    always_comb begin
        w_state_next = r_state;
        if (pause_p && !adj) begin
            w_state_next = (r_state == c_st_run) ? c_st_pause : c_st_run;
        end
    end

    always_comb begin
        w_paused = (r_state == c_st_pause);
    end

    // Adjust overrides counting; adjust increments never carry across fields
    always_comb begin
        w_min_next  = r_min;
        w_sec_next  = r_sec;
        w_wrap_next = 1'b0;
        if (adj) begin
            if (tick_adj) begin
                if (sel) begin
                    w_sec_next = (r_sec == c_sec_max) ? '0 : r_sec + c_sec_one;
                end else begin
                    w_min_next = (r_min == c_min_max) ? '0 : r_min + c_min_one;
                end
            end
        end else if ((r_state == c_st_run) && tick_1hz) begin
            if (r_sec == c_sec_max) begin
                w_sec_next = '0;
                if (r_min == c_min_max) begin
                    w_min_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_min_next = r_min + c_min_one;
                end
            end else begin
                w_sec_next = r_sec + c_sec_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min       <= '0;
            r_sec       <= '0;
            r_adjusting <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_min       <= w_min_next;
            r_sec       <= w_sec_next;
            r_adjusting <= adj;
            r_wrap      <= w_wrap_next;
        end
    end

    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign paused    = w_paused;
    assign adjusting = r_adjusting;
    assign wrap_p    = r_wrap;

`ifdef STOPWATCH_BLINK_EN
    logic r_blink;
    logic w_blink_next;
    logic r_min_blank;
    logic r_sec_blank;

    always_comb begin
        w_blink_next = 1'b0;
        if (adj) begin
            w_blink_next = tick_adj ? ~r_blink : r_blink;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink     <= 1'b0;
            r_min_blank <= 1'b0;
            r_sec_blank <= 1'b0;
        end else begin
            r_blink     <= w_blink_next;
            r_min_blank <= w_blink_next & ~sel;
            r_sec_blank <= w_blink_next & sel;
        end
    end

    assign min_blank = r_min_blank;
    assign sec_blank = r_sec_blank;
`else
    assign min_blank = 1'b0;
    assign sec_blank = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_adj_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_adj_ctrl
//  Purpose  : Scoreboard bench for stopwatch_adj_ctrl (honours STOPWATCH_BLINK_EN)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_adj_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_adj = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       pause_p = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       paused;
    logic       adjusting;
    logic       wrap_p;
    logic       min_blank;
    logic       sec_blank;

    typedef struct packed {
        logic [5:0] mm;
        logic [5:0] ss;
        logic       pz;
        logic       aj;
        logic       wr;
        logic       mb;
        logic       sb;
    } exp_t;

    exp_t q_exp[$];
    int   q_tag[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_blink = 1'b0;

    stopwatch_adj_ctrl #(
        .MIN_W(6), .SEC_W(6), .MIN_MAX(59), .SEC_MAX(59)
    ) u_dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .adj(adj), .sel(sel), .pause_p(pause_p),
        .minutes(minutes), .seconds(seconds), .paused(paused),
        .adjusting(adjusting), .wrap_p(wrap_p),
        .min_blank(min_blank), .sec_blank(sec_blank)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; inputs change 1 time unit after the edge
    task automatic cyc(input logic r, input logic t1, input logic ta,
                       input logic a, input logic s, input logic p);
        rst = r; tick_1hz = t1; tick_adj = ta; adj = a; sel = s; pause_p = p;
        @(posedge clk);
        #1;
        if (r || !a) exp_blink = 1'b0;
        else if (ta) exp_blink = ~exp_blink;
        tick_1hz = 1'b0; tick_adj = 1'b0; pause_p = 1'b0; rst = 1'b0;
    endtask

    task automatic expect_st(input int tag, input int mm, input int ss,
                             input logic pz, input logic aj, input logic wr);
        exp_t e;
        e.mm = 6'(mm);
        e.ss = 6'(ss);
        e.pz = pz;
        e.aj = aj;
        e.wr = wr;
`ifdef STOPWATCH_BLINK_EN
        e.mb = exp_blink & ~sel;
        e.sb = exp_blink & sel;
`else
        e.mb = 1'b0;
        e.sb = 1'b0;
`endif
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // Monitor: outputs are stable mid-cycle; compare against queued expectation
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            exp_t g;
            int   t;
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            g = {minutes, seconds, paused, adjusting, wrap_p, min_blank, sec_blank};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL chk%0d: got %0d:%0d p=%0b a=%0b w=%0b mb=%0b sb=%0b, want %0d:%0d p=%0b a=%0b w=%0b mb=%0b sb=%0b",
                         t, g.mm, g.ss, g.pz, g.aj, g.wr, g.mb, g.sb,
                         e.mm, e.ss, e.pz, e.aj, e.wr, e.mb, e.sb);
            end
        end
    end

    initial begin
        int k;
        k = 0;
        // reset with tick_1hz active
        cyc(1, 1, 0, 0, 0, 0); expect_st(k++, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0); expect_st(k++, 0, 0, 0, 0, 0);
        // 61 seconds
        for (int i = 1; i <= 61; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (i == 59) expect_st(k++, 0, 59, 0, 0, 0);
            if (i == 60) expect_st(k++, 1, 0, 0, 0, 0);
            if (i == 61) expect_st(k++, 1, 1, 0, 0, 0);
        end
        // preload 59:58
        for (int i = 0; i < 58; i++) cyc(0, 0, 1, 1, 0, 0);
        expect_st(k++, 59, 1, 0, 1, 0);
        for (int i = 0; i < 57; i++) cyc(0, 0, 1, 1, 1, 0);
        expect_st(k++, 59, 58, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0); expect_st(k++, 59, 58, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); expect_st(k++, 59, 59, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); expect_st(k++, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0); expect_st(k++, 0, 0, 0, 0, 0);
        // reach 3:59 via adjust, then seconds wrap without carry
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 1, 1, 1, 0);
        expect_st(k++, 3, 59, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0); expect_st(k++, 3, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 1, 0); expect_st(k++, 3, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0); expect_st(k++, 3, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 1, 0); expect_st(k++, 3, 1, 0, 1, 0);
        // minutes wrap in adjust, seconds untouched
        for (int i = 0; i < 56; i++) cyc(0, 0, 1, 1, 0, 0);
        expect_st(k++, 59, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0); expect_st(k++, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0); expect_st(k++, 0, 2, 0, 1, 0);
        // pause behaviour at 0:10
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0); expect_st(k++, 0, 10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1); expect_st(k++, 0, 10, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        expect_st(k++, 0, 10, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0); expect_st(k++, 0, 10, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 1); expect_st(k++, 0, 10, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0); expect_st(k++, 0, 10, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); expect_st(k++, 0, 10, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1); expect_st(k++, 0, 10, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); expect_st(k++, 0, 11, 0, 0, 0);
        // pause with simultaneous tick: tick counts, then pauses
        cyc(0, 1, 0, 0, 0, 1); expect_st(k++, 0, 12, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1); expect_st(k++, 0, 12, 0, 0, 0);
        // adj rising with tick_1hz drops the tick; tick_adj ignored without adj
        cyc(0, 1, 0, 1, 0, 0); expect_st(k++, 0, 12, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0); expect_st(k++, 0, 12, 0, 0, 0);
        // blink on minutes field
        cyc(0, 0, 1, 1, 0, 0); expect_st(k++, 1, 12, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0); expect_st(k++, 2, 12, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0); expect_st(k++, 3, 12, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0); expect_st(k++, 3, 12, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0); expect_st(k++, 3, 12, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); expect_st(k++, 3, 13, 0, 0, 0);
        // reset mid-run overrides everything
        cyc(1, 1, 1, 1, 1, 1); expect_st(k++, 0, 0, 0, 0, 0);
        // drain with bounded wait
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
        if (q_exp.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
